// File: rtl/mem_ctrl_mp.sv
// mem_ctrl_mp: multi-port memory controller in front of a byte-wide synchronous RAM.
// N requesters are arbitrated (round-robin or fixed priority), and each granted
// 1-4 byte little-endian access is serialised into single-byte RAM cycles.
// Reads tolerate a fixed RAM read latency and return sign/zero-extended data.
//
// Handshake: a requester raises req_valid_i[p] with its command fields stable and
// holds it until resp_done_o[p] pulses for exactly one cycle. Command fields are
// latched at grant, so later changes on that port are ignored until completion.
// After the done pulse the requester either drops req_valid_i[p] or leaves it
// high to present a new command; the next grant happens no earlier than the
// cycle after the done pulse.
module mem_ctrl_mp #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_RD_LATENCY = 1,
  parameter int ARB_MODE       = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_valid_i,
  input  logic [NUM_PORTS-1:0]             req_we_i,
  input  logic [NUM_PORTS-1:0]             req_signed_i,
  input  logic [2*NUM_PORTS-1:0]           req_len_i,
  input  logic [ADDR_WIDTH*NUM_PORTS-1:0]  req_addr_i,
  input  logic [32*NUM_PORTS-1:0]          req_wdata_i,
  output logic [NUM_PORTS-1:0]             resp_done_o,
  output logic [31:0]                      resp_rdata_o,
  output logic                             busy_o,
  output logic                             ram_rw_o,
  output logic [ADDR_WIDTH-1:0]            ram_addr_o,
  output logic [7:0]                       ram_wdata_o,
  input  logic [7:0]                       ram_rdata_i,
  output logic [1:0]                       state_dbg_o
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic [PW-1:0]               rr_q, rr_d;
  logic [PW-1:0]               port_q, port_d;
  logic                        we_q, we_d;
  logic                        sgn_q, sgn_d;
  logic [1:0]                  len_q, len_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [31:0]                 wdata_q, wdata_d;
  logic [1:0]                  k_q, k_d;
  logic [1:0]                  cap_k_q, cap_k_d;
  logic [RAM_RD_LATENCY-1:0]   pipe_q, pipe_d;
  logic [3:0][7:0]             lanes_q, lanes_d;
  logic [NUM_PORTS-1:0]        resp_done_q, resp_done_d;
  logic [31:0]                 resp_rdata_q, resp_rdata_d;
  logic                        busy_q, busy_d;
  logic                        ram_rw_q, ram_rw_d;
  logic [ADDR_WIDTH-1:0]       ram_addr_q, ram_addr_d;
  logic [7:0]                  ram_wdata_q, ram_wdata_d;

  logic                        gnt_found;
  logic [PW-1:0]               gnt_idx;
  int                          rr_idx;
  logic                        issue;
  logic                        capture;

  // Extend an assembled little-endian read to 32 bits according to its length.
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] len,
                                         input logic sgn);
    logic [31:0] r;
    r = w;
    case (len)
      2'd0:    r = {{24{sgn & w[7]}},  w[7:0]};
      2'd1:    r = {{16{sgn & w[15]}}, w[15:0]};
      2'd2:    r = {{8{sgn & w[23]}},  w[23:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  assign resp_done_o  = resp_done_q;
  assign resp_rdata_o = resp_rdata_q;
  assign busy_o       = busy_q;
  assign ram_rw_o     = ram_rw_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_wdata_o  = ram_wdata_q;
  assign state_dbg_o  = state_q;

  // A read byte is presented on every XFER cycle of a read; the shift register
  // tracks when each one comes back from the RAM.
  assign issue   = (state_q == S_XFER) && !we_q;
  assign capture = pipe_q[RAM_RD_LATENCY-1];

  // Pick the port to grant: lowest index in fixed mode, or first valid port
  // after the last winner in round-robin mode.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    rr_idx    = 0;
    if (ARB_MODE == 1) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (req_valid_i[i]) begin
          gnt_found = 1'b1;
          gnt_idx   = PW'(i);
        end
      end
    end else begin
      // Walk the search order backwards so the earliest candidate is assigned last.
      for (int i = NUM_PORTS; i >= 1; i--) begin
        rr_idx = (int'(rr_q) + i) % NUM_PORTS;
        if (req_valid_i[rr_idx]) begin
          gnt_found = 1'b1;
          gnt_idx   = PW'(rr_idx);
        end
      end
    end
  end

  // Next-state and registered-output logic for the transfer FSM.
  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    port_d       = port_q;
    we_d         = we_q;
    sgn_d        = sgn_q;
    len_d        = len_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    k_d          = k_q;
    cap_k_d      = cap_k_q;
    lanes_d      = lanes_q;
    resp_done_d  = '0;
    resp_rdata_d = resp_rdata_q;
    ram_rw_d     = 1'b0;
    ram_addr_d   = '0;
    ram_wdata_d  = 8'h00;
    pipe_d       = (pipe_q << 1) | RAM_RD_LATENCY'(issue);

    // Returning read bytes land in consecutive lanes, independent of state.
    if (capture) begin
      lanes_d[cap_k_q] = ram_rdata_i;
      cap_k_d          = cap_k_q + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          state_d     = S_XFER;
          port_d      = gnt_idx;
          we_d        = req_we_i[gnt_idx];
          sgn_d       = req_signed_i[gnt_idx];
          len_d       = req_len_i[int'(gnt_idx)*2 +: 2];
          addr_d      = req_addr_i[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d     = req_wdata_i[int'(gnt_idx)*32 +: 32];
          k_d         = 2'd0;
          cap_k_d     = 2'd0;
          lanes_d     = '0;
          ram_rw_d    = req_we_i[gnt_idx];
          ram_addr_d  = req_addr_i[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          ram_wdata_d = req_we_i[gnt_idx] ? req_wdata_i[int'(gnt_idx)*32 +: 8] : 8'h00;
          if (ARB_MODE == 0) begin
            rr_d = gnt_idx;
          end
        end
      end
      S_XFER: begin
        if (k_q == len_q) begin
          if (we_q) begin
            state_d     = S_DONE;
            resp_done_d = NUM_PORTS'(1) << port_q;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          k_d         = k_q + 2'd1;
          ram_rw_d    = we_q;
          ram_addr_d  = addr_q + ADDR_WIDTH'(k_d);
          ram_wdata_d = we_q ? wdata_q[{k_d, 3'b000} +: 8] : 8'h00;
        end
      end
      S_WAIT: begin
        // Finish when the final byte arrives; it is folded in combinationally.
        if (capture && (cap_k_q == len_q)) begin
          state_d      = S_DONE;
          resp_done_d  = NUM_PORTS'(1) << port_q;
          resp_rdata_d = extend(lanes_d, len_q, sgn_q);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_q         <= PW'(NUM_PORTS - 1);
      port_q       <= '0;
      we_q         <= 1'b0;
      sgn_q        <= 1'b0;
      len_q        <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      k_q          <= 2'd0;
      cap_k_q      <= 2'd0;
      pipe_q       <= '0;
      lanes_q      <= '0;
      resp_done_q  <= '0;
      resp_rdata_q <= '0;
      busy_q       <= 1'b0;
      ram_rw_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      port_q       <= port_d;
      we_q         <= we_d;
      sgn_q        <= sgn_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      k_q          <= k_d;
      cap_k_q      <= cap_k_d;
      pipe_q       <= pipe_d;
      lanes_q      <= lanes_d;
      resp_done_q  <= resp_done_d;
      resp_rdata_q <= resp_rdata_d;
      busy_q       <= busy_d;
      ram_rw_q     <= ram_rw_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl_mp.sv
// Bench for mem_ctrl_mp: instance A (latency 1, round-robin) and instance B
// (latency 2, fixed priority), each with its own byte RAM model.
module tb_mem_ctrl_mp;

  localparam int NP    = 2;
  localparam int AW    = 32;
  localparam int LAT_A = 1;
  localparam int LAT_B = 2;

  logic clk = 1'b0;
  logic rst;

  logic [NP-1:0]    req_valid  [2];
  logic [NP-1:0]    req_we     [2];
  logic [NP-1:0]    req_signed [2];
  logic [2*NP-1:0]  req_len    [2];
  logic [AW*NP-1:0] req_addr   [2];
  logic [32*NP-1:0] req_wdata  [2];
  logic [NP-1:0]    resp_done  [2];
  logic [31:0]      resp_rdata [2];
  logic             busy       [2];
  logic             ram_rw     [2];
  logic [AW-1:0]    ram_addr   [2];
  logic [7:0]       ram_wdata  [2];
  logic [7:0]       ram_rdata  [2];
  logic [1:0]       state_dbg  [2];

  logic [7:0] mem0 [4096];
  logic [7:0] mem1 [4096];
  logic [7:0] rdp0, rdp1a, rdp1b;

  typedef struct {
    int          sel;
    int          port;
    logic        we;
    logic        sgn;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [16];

  int checks = 0;
  int errors = 0;
  logic [NP+31:0] exp_q0 [$];
  logic [NP+31:0] exp_q1 [$];
  logic [31:0]    last_rd [2];
  logic [NP+31:0] mon_e0, mon_e1;

  // Clock generation
  always #5 clk = ~clk;

  mem_ctrl_mp #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .RAM_RD_LATENCY(LAT_A), .ARB_MODE(0)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid[0]), .req_we_i(req_we[0]), .req_signed_i(req_signed[0]),
    .req_len_i(req_len[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .resp_done_o(resp_done[0]), .resp_rdata_o(resp_rdata[0]), .busy_o(busy[0]),
    .ram_rw_o(ram_rw[0]), .ram_addr_o(ram_addr[0]), .ram_wdata_o(ram_wdata[0]),
    .ram_rdata_i(ram_rdata[0]), .state_dbg_o(state_dbg[0])
  );

  mem_ctrl_mp #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .RAM_RD_LATENCY(LAT_B), .ARB_MODE(1)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid[1]), .req_we_i(req_we[1]), .req_signed_i(req_signed[1]),
    .req_len_i(req_len[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .resp_done_o(resp_done[1]), .resp_rdata_o(resp_rdata[1]), .busy_o(busy[1]),
    .ram_rw_o(ram_rw[1]), .ram_addr_o(ram_addr[1]), .ram_wdata_o(ram_wdata[1]),
    .ram_rdata_i(ram_rdata[1]), .state_dbg_o(state_dbg[1])
  );

  // RAM models: writes at the clock edge, reads return after 1 or 2 cycles.
  always @(posedge clk) begin
    if (ram_rw[0]) mem0[ram_addr[0][11:0]] <= ram_wdata[0];
    if (ram_rw[1]) mem1[ram_addr[1][11:0]] <= ram_wdata[1];
    rdp0  <= mem0[ram_addr[0][11:0]];
    rdp1a <= mem1[ram_addr[1][11:0]];
    rdp1b <= rdp1a;
  end
  assign ram_rdata[0] = rdp0;
  assign ram_rdata[1] = rdp1b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every done pulse is matched against the oldest expected response.
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_done[0] != '0) begin
        if (exp_q0.size() == 0) check("sb_a_unexpected_done", {resp_done[0], resp_rdata[0]}, '0);
        else begin
          mon_e0 = exp_q0.pop_front();
          check("sb_a_resp", {resp_done[0], resp_rdata[0]}, mon_e0);
        end
      end
      if (resp_done[1] != '0) begin
        if (exp_q1.size() == 0) check("sb_b_unexpected_done", {resp_done[1], resp_rdata[1]}, '0);
        else begin
          mon_e1 = exp_q1.pop_front();
          check("sb_b_resp", {resp_done[1], resp_rdata[1]}, mon_e1);
        end
      end
    end
  end

  task automatic push_exp(input int s, input int p, input logic [31:0] rd);
    logic [NP-1:0] oh;
    oh    = '0;
    oh[p] = 1'b1;
    if (s == 0) exp_q0.push_back({oh, rd});
    else        exp_q1.push_back({oh, rd});
  endtask

  task automatic drive_port(input int s, input int p, input logic we, input logic sgn,
                            input logic [1:0] len, input logic [31:0] addr,
                            input logic [31:0] wdata);
    req_we[s][p]             = we;
    req_signed[s][p]         = sgn;
    req_len[s][2*p +: 2]     = len;
    req_addr[s][p*AW +: AW]  = addr;
    req_wdata[s][p*32 +: 32] = wdata;
    req_valid[s][p]          = 1'b1;
  endtask

  task automatic wait_dones(input int s, input int cnt, input int budget, output int ticks);
    int seen;
    seen  = 0;
    ticks = 0;
    while (seen < cnt && ticks < budget) begin
      tick();
      ticks++;
      if (resp_done[s] != '0) seen++;
    end
    check("wait_dones", seen, cnt);
  endtask

  // One full transaction with per-cycle RAM-side checks and a latency check.
  task automatic run_txn(input vec_t v);
    int n, lat, t;
    bit got;
    logic [31:0] ea;
    logic [7:0]  ew;
    n   = int'(v.len) + 1;
    lat = v.we ? n + 1 : n + ((v.sel == 0) ? LAT_A : LAT_B) + 1;
    if (!v.we) last_rd[v.sel] = v.exp_rdata;
    push_exp(v.sel, v.port, last_rd[v.sel]);
    drive_port(v.sel, v.port, v.we, v.sgn, v.len, v.addr, v.wdata);
    t   = 0;
    got = 1'b0;
    while (!got && t < 40) begin
      tick();
      t++;
      if (t <= n) begin
        ea = v.addr + 32'(t - 1);
        ew = v.we ? v.wdata[8*(t-1) +: 8] : 8'h00;
        check("xfer_rw", ram_rw[v.sel], v.we);
        check("xfer_addr", ram_addr[v.sel], ea);
        check("xfer_wdata", ram_wdata[v.sel], ew);
        check("xfer_busy", busy[v.sel], 1'b1);
      end else if (t == n + 1) begin
        check("post_xfer_idle", {ram_rw[v.sel], ram_addr[v.sel], ram_wdata[v.sel]}, '0);
      end
      if (resp_done[v.sel] != '0) got = 1'b1;
    end
    check("done_seen", got, 1'b1);
    check("done_latency", t, lat);
    req_valid[v.sel][v.port] = 1'b0;
    tick();
    check("busy_after_done", busy[v.sel], 1'b0);
  endtask

  initial begin
    int t;
    logic [31:0] base;

    for (int i = 0; i < 4096; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = '0; req_we[s] = '0; req_signed[s] = '0;
      req_len[s] = '0; req_addr[s] = '0; req_wdata[s] = '0;
      last_rd[s] = 32'h0;
    end

    // Reset and idle output values
    rst = 1'b1;
    repeat (3) tick();
    for (int s = 0; s < 2; s++) begin
      check("reset_outputs", {resp_done[s], resp_rdata[s], busy[s], ram_rw[s], ram_addr[s],
                              ram_wdata[s]}, '0);
      check("reset_state", state_dbg[s], 2'd0);
    end
    rst = 1'b0;
    tick();

    // Round-robin: both ports held, grants alternate starting at port 0
    push_exp(0, 0, 32'h0); push_exp(0, 1, 32'h0);
    push_exp(0, 0, 32'h0); push_exp(0, 1, 32'h0);
    drive_port(0, 0, 1'b1, 1'b0, 2'd0, 32'h40, 32'h55);
    drive_port(0, 1, 1'b1, 1'b0, 2'd0, 32'h41, 32'h66);
    wait_dones(0, 4, 40, t);
    check("rr_cycles", t, 11);
    req_valid[0] = '0;
    tick();

    // Fixed priority: port 0 wins while held, then port 1
    push_exp(1, 0, 32'h0); push_exp(1, 0, 32'h0); push_exp(1, 0, 32'h0);
    drive_port(1, 0, 1'b1, 1'b0, 2'd0, 32'h50, 32'h77);
    drive_port(1, 1, 1'b1, 1'b0, 2'd0, 32'h51, 32'h88);
    wait_dones(1, 3, 40, t);
    check("fp_cycles", t, 8);
    req_valid[1][0] = 1'b0;
    push_exp(1, 1, 32'h0);
    wait_dones(1, 1, 20, t);
    check("fp_port1_cycles", t, 3);
    req_valid[1][1] = 1'b0;
    tick();

    // Table of single transactions
    tbl[0]  = '{0, 0, 1'b1, 1'b0, 2'd3, 32'h00000100, 32'hA1B2C3D4, 32'h0};
    tbl[1]  = '{0, 1, 1'b0, 1'b0, 2'd3, 32'h00000100, 32'h0, 32'hA1B2C3D4};
    tbl[2]  = '{0, 0, 1'b0, 1'b1, 2'd1, 32'h00000102, 32'h0, 32'hFFFFA1B2};
    tbl[3]  = '{0, 1, 1'b0, 1'b0, 2'd0, 32'h00000103, 32'h0, 32'h000000A1};
    tbl[4]  = '{0, 1, 1'b0, 1'b1, 2'd0, 32'h00000101, 32'h0, 32'hFFFFFFC3};
    tbl[5]  = '{0, 0, 1'b1, 1'b0, 2'd3, 32'hFFFFFFFE, 32'h11223344, 32'h0};
    tbl[6]  = '{0, 1, 1'b0, 1'b0, 2'd3, 32'hFFFFFFFE, 32'h0, 32'h11223344};
    tbl[7]  = '{0, 0, 1'b0, 1'b1, 2'd3, 32'h00000100, 32'h0, 32'hA1B2C3D4};
    tbl[8]  = '{1, 0, 1'b1, 1'b0, 2'd0, 32'h00000200, 32'h00000080, 32'h0};
    tbl[9]  = '{1, 1, 1'b0, 1'b1, 2'd0, 32'h00000200, 32'h0, 32'hFFFFFF80};
    tbl[10] = '{1, 1, 1'b0, 1'b0, 2'd0, 32'h00000200, 32'h0, 32'h00000080};
    tbl[11] = '{1, 0, 1'b1, 1'b0, 2'd1, 32'h00000210, 32'h00008534, 32'h0};
    tbl[12] = '{1, 1, 1'b0, 1'b1, 2'd1, 32'h00000210, 32'h0, 32'hFFFF8534};
    tbl[13] = '{1, 0, 1'b1, 1'b0, 2'd2, 32'h00000300, 32'hFF830201, 32'h0};
    tbl[14] = '{1, 1, 1'b0, 1'b0, 2'd3, 32'h00000300, 32'h0, 32'h00830201};
    tbl[15] = '{1, 1, 1'b0, 1'b0, 2'd2, 32'h00000300, 32'h0, 32'h00830201};
    for (int i = 0; i < 16; i++) run_txn(tbl[i]);

    // Three-byte signed read, re-requested in the DONE cycle
    last_rd[1] = 32'hFF830201;
    push_exp(1, 1, 32'hFF830201);
    push_exp(1, 1, 32'hFF830201);
    drive_port(1, 1, 1'b0, 1'b1, 2'd2, 32'h300, 32'h0);
    wait_dones(1, 1, 30, t);
    check("rd3_latency", t, 6);
    tick();
    check("no_grant_in_done_busy", busy[1], 1'b0);
    check("no_grant_in_done_state", state_dbg[1], 2'd0);
    check("no_grant_in_done_pulse", resp_done[1], 2'b00);
    wait_dones(1, 1, 30, t);
    check("rd3_regrant_latency", t, 6);
    req_valid[1] = '0;
    tick();

    // Reset during the second XFER cycle of a word write
    base = 32'h500;
    drive_port(0, 0, 1'b1, 1'b0, 2'd3, base, 32'hCAFEF00D);
    tick();
    tick();
    check("pre_rst_addr", ram_addr[0], 32'h501);
    rst = 1'b1;
    req_valid[0] = '0;
    tick();
    check("rst_abort_rw", ram_rw[0], 1'b0);
    check("rst_abort_busy", busy[0], 1'b0);
    check("rst_abort_done", resp_done[0], 2'b00);
    rst = 1'b0;
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    t = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (resp_done[0] != '0 || ram_rw[0]) t++;
    end
    check("rst_no_activity", t, 0);
    check("rst_no_write_502", mem0[12'h502], 8'h00);
    check("rst_no_write_503", mem0[12'h503], 8'h00);

    // After reset port 0 is granted first even though it won last
    push_exp(0, 0, 32'h000000D4);
    push_exp(0, 1, 32'h000000C3);
    drive_port(0, 0, 1'b0, 1'b0, 2'd0, 32'h100, 32'h0);
    drive_port(0, 1, 1'b0, 1'b0, 2'd0, 32'h101, 32'h0);
    wait_dones(0, 1, 20, t);
    check("post_rst_first_latency", t, 3);
    req_valid[0][0] = 1'b0;
    wait_dones(0, 1, 20, t);
    check("post_rst_second_latency", t, 4);
    req_valid[0][1] = 1'b0;
    tick();
    tick();

    check("sb_a_drained", exp_q0.size(), 0);
    check("sb_b_drained", exp_q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl_mp.md
Name: mem_ctrl_mp

Overview:
- Parametrised multi-port memory controller between N requesters (e.g. instruction fetch, load/store unit, prefetcher) and the single byte-wide synchronous RAM.
- Arbitrates requests in round-robin or fixed-priority mode.
- Serialises each 1–4 byte little-endian read or write into byte accesses, tolerating a configurable RAM read latency.
- Returns sign- or zero-extended read data with a per-port done pulse.

Parameters:
- NUM_PORTS, 2, number of requester ports (1..8).
- ADDR_WIDTH, 32, width of request and RAM addresses.
- RAM_RD_LATENCY, 1, cycles from ram_addr presented (read) to byte valid on ram_rdata (1..4).
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_PORTS  request pending per port; held until that port's resp_done.
- req_we  in  NUM_PORTS  1 = write, 0 = read.
- req_signed  in  NUM_PORTS  sign-extend read data.
- req_len  in  2*NUM_PORTS  byte count minus 1 (0 = byte, 1 = half, 2 = three bytes, 3 = word).
- req_addr  in  ADDR_WIDTH*NUM_PORTS  byte base address; port p occupies slice [p*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  32*NUM_PORTS  write data, little-endian.
- resp_done  out  NUM_PORTS  one-cycle completion pulse, one-hot.
- resp_rdata  out  32  read data, valid while resp_done is high.
- busy  out  1  high whenever state != IDLE.
- ram_rw  out  1  1 = write.
- ram_addr  out  ADDR_WIDTH  RAM byte address.
- ram_wdata  out  8  RAM write byte.
- ram_rdata  in  8  RAM read byte.

Behaviour:
- Reset (rst high at a clk edge):
  - state = IDLE; resp_done = 0; resp_rdata = 0; busy = 0; ram_rw = 0; ram_addr = 0; ram_wdata = 0.
  - Round-robin pointer = NUM_PORTS-1, so port 0 has priority on the first grant.
  - Reset mid-transfer aborts the transfer immediately: no done pulse, no further RAM writes.
- All outputs are registered.
- States: IDLE -> XFER -> WAIT (reads only) -> DONE -> IDLE.
- IDLE:
  - If any req_valid is set, grant one port p in cycle G.
  - Latch addr, len, we, signed and wdata for port p; n = len+1.
  - Go to XFER; ram outputs stay at idle values.
  - Round-robin: search from pointer+1 upward modulo NUM_PORTS; pointer = p on grant.
  - Fixed priority: lowest index with req_valid wins; pointer unused.
- XFER, cycle G+1+k for k = 0..n-1:
  - ram_addr = base+k, modulo 2^ADDR_WIDTH, so addresses wrap.
  - ram_rw = we.
  - ram_wdata = wdata[8k+7:8k] for writes; 0 for reads.
- After XFER, ram_rw = 0, ram_addr = 0 and ram_wdata = 0 again.
- Writes: after the last byte go directly to DONE; resp_done[p] is high in cycle G+n+1.
- Reads:
  - The byte for address base+k is valid on ram_rdata in cycle G+1+k+RAM_RD_LATENCY and is captured into byte lane k at the end of that cycle.
  - WAIT covers the remaining latency cycles.
  - resp_done[p] is high in cycle G+n+RAM_RD_LATENCY+1, with resp_rdata assembled in the same cycle.
- Read extension:
  - Unsigned: bits above byte n-1 are 0.
  - Signed: bits above byte n-1 copy bit 8n-1.
  - len = 3: no extension.
- resp_rdata:
  - Holds its value after DONE until the next read completes.
  - Writes leave resp_rdata unchanged.
- DONE lasts exactly 1 cycle and makes no grant in that cycle.
  - The requester must drop req_valid, or present a new request, by the cycle after done.
  - Earliest next grant is in cycle DONE+1.
- req_valid dropped mid-transfer: the transfer still completes and pulses resp_done (harmless).
- Request inputs are ignored after the grant; latched values are used throughout.
- Minimum occupancy:
  - Byte write: 3 cycles (grant, 1 XFER, DONE).
  - Word read at latency 1: 7 cycles.

Test Plan:
- Reset, then port 0 writes word 0xA1B2C3D4 to 0x100 -> ram_rw=1 and ram_addr/ram_wdata = 0x100/D4, 0x101/C3, 0x102/B2, 0x103/A1 in cycles G+1..G+4; resp_done[0] in G+5.
- RAM_RD_LATENCY=2; port 1 reads signed byte 0x80 at 0x200 -> resp_rdata=0xFFFFFF80; unsigned -> 0x00000080; signed half with bytes 0x34,0x85 -> 0xFFFF8534; resp_done[1] at G+4 for the byte read.
- Both ports request continuously with ARB_MODE=0 -> grants alternate 0,1,0,1; with ARB_MODE=1 -> port 0 always wins while held.
- Word write at 0xFFFFFFFE with ADDR_WIDTH=32 -> ram_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Assert rst during XFER cycle 2 of a word write -> no resp_done; ram_rw=0 from the next cycle; a subsequent port-0 request is granted first.
- Three-byte read (len=2) signed of bytes 0x01,0x02,0x83 -> resp_rdata=0xFF830201; the same request issued in the DONE cycle is not granted until the following cycle.
